seg7_scan_capture: RTL and testbench
====================================

// Module: seg7_scan_capture
// PURPOSE
//  Reader side of the multiplexed 4-digit 7-segment bus driven by the stopwatch counter.
//  Samples the active-low digit selector and segment lines, waits for each digit to settle, and decodes the pattern to BCD.
//  Publishes a coherent 4-digit frame: minute units, second tens, second units, tenths.
//  Used for on-board self-check and for capturing display contents in bench/loopback setups.
// PARAMETERS
//  SETTLE_CYCLES  1000    cycles selector+segments must be stable before a digit is sampled (16-bit counter)
//  FRAME_TIMEOUT  100000  cycles without any sample before stale asserts (17-bit counter)
// PORTS
//  clk_placa        in   1  board clock; sole clock domain
//  rst              in   1  synchronous, active-high reset
//  seletor_display  in   4  active-low one-hot digit select; [4] = digit 1 (minute units) ... [1] = digit 4 (tenths)
//  segmentos        in   8  active-low segments; [6:0] = g..a, [7] = decimal point
//  num1..num4       out  4  each; decoded BCD digits 1..4 of the last complete frame; 4'hF = undecodable
//  ponto            out  4  dp lit (1 = on) per digit; [4] = digit 1 ... [1] = digit 4
//  frame_valid      out  1  one-cycle pulse when num*/ponto are updated
//  digit_err        out  1  one-cycle pulse on sampling an undecodable segment pattern
//  dp_err           out  1  one-cycle pulse on a dp pattern mismatch (see CONFIGURATION)
//  stale            out  1  level; no digit sampled for FRAME_TIMEOUT cycles
// BEHAVIOUR
//  - Reset: num1..num4=0, ponto=0, frame_valid=0, digit_err=0, dp_err=0, stale=0, capture mask=0, counters=0, state=IDLE.
//  - Inputs are registered twice before use; the latency below counts from the registered inputs.
//  - Legal selectors: 0111, 1011, 1101, 1110. Any other value (blank 1111, multi-hot) forces IDLE with no capture.
//  - FSM states:
//    IDLE:   go to SETTLE when a legal selector is present. Clear the settle counter.
//    SETTLE: count while selector and segmentos equal their previous-cycle values.
//            Any change restarts the count at 0. Selector becomes illegal -> IDLE.
//            The count reaches SETTLE_CYCLES -> SAMPLE.
//    SAMPLE: one cycle. Decode segmentos[6:0] into the shadow register for the selected digit.
//            Store dp = ~segmentos[7]. Set that digit's bit in the capture mask. Go to HOLD.
//    HOLD:   wait for the selector to change. Legal new value -> SETTLE; illegal -> IDLE.
//            A segment change under the same selector does not resample.
//  - Decode table (exact inverse of the encoder):
//    0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001,
//    5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
//    Any other pattern, including 1111111, decodes to 4'hF and pulses digit_err in the cycle after SAMPLE.
//  - Resampling the same digit before the frame completes overwrites its shadow value. The mask bit stays set.
//  - Frame completion: when the mask reaches 4'b1111, the next cycle copies the shadow registers to num*/ponto.
//    In that same cycle frame_valid pulses and the mask is cleared. Outputs change only on frame_valid.
//  - Stale counter: increments every cycle and resets on each SAMPLE. It saturates at FRAME_TIMEOUT, which sets stale.
//    stale clears on the next frame_valid, not on the next sample.
//  - rst mid-operation: takes effect on the next edge and overrides all states. Partial shadow data is discarded.
// CONFIGURATION
//  SEG7_SCAN_DP_CHECK_EN defined:
//    Expected dp pattern is digit1 on, digit2 off, digit3 on, digit4 off (ponto = 4'b1010).
//    On frame completion, any mismatch pulses dp_err in the same cycle as frame_valid.
//  SEG7_SCAN_DP_CHECK_EN undefined: dp_err is tied 0. ponto is still reported raw.
// STRUCTURE
//  - Shared header seg7_defs.vh holds:
//    - selector codes SEL_D1..SEL_D4
//    - the SEG_0..SEG_9 patterns and SEG_BLANK
//    - BCD_ERR = 4'hF
//    - FSM state encodings
//    The encoder also includes this header, so encoder and decoder can never diverge.
//  - Sub-module seg7_decode: combinational seg[6:0] -> {bcd[3:0], invalid}. All sequencing stays in the top module.
// TESTING
//  1. Scan digits 3,4,5,7 with dp 1,0,1,0, dwell 12500 cycles each.
//     -> After 4 dwells: frame_valid pulse, num1..4 = 3,4,5,7, ponto=4'b1010, dp_err=0.
//  2. Digit 2 dwells only 500 cycles (< SETTLE_CYCLES).
//     -> No capture of digit 2 and no frame_valid until digit 2 dwells >= 1000 cycles.
//  3. Digit 3 pattern 1111111 -> digit_err pulse. The next frame has num3=4'hF; the other digits are correct.
//  4. Selector held 1111 for 100000 cycles -> stale=1.
//     Normal scan resumes -> stale stays 1 until the first frame_valid, then 0.
//  5. Assert rst for 1 cycle mid-SETTLE on digit 3 of a frame.
//     -> Next cycle all outputs are 0. The first frame_valid only after all four digits are re-sampled.
//  6. With SEG7_SCAN_DP_CHECK_EN, scan dp 0,1,0,1 -> dp_err pulses with frame_valid.
//     Without the macro, the same stimulus -> dp_err stays 0 and ponto=4'b0101.

Source files
------------

// File: rtl/seg7_scan_capture_pkg.sv
// seg7_scan_capture_pkg: shared selector codes, segment patterns, BCD error code and FSM states
package seg7_scan_capture_pkg;
  localparam logic [3:0] SEL_D1 = 4'b0111;
  localparam logic [3:0] SEL_D2 = 4'b1011;
  localparam logic [3:0] SEL_D3 = 4'b1101;
  localparam logic [3:0] SEL_D4 = 4'b1110;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] BCD_ERR = 4'hF;
  localparam logic [3:0] DP_EXPECTED = 4'b1010;
  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_HOLD} state_t;
  function automatic logic sel_legal(input logic [3:0] sel);
    return sel == SEL_D1 || sel == SEL_D2 || sel == SEL_D3 || sel == SEL_D4;
  endfunction
endpackage

// File: rtl/seg7_scan_capture_decode.sv
// seg7_scan_capture_decode: active-low 7-segment pattern to BCD, BCD_ERR for anything else
//   i_seg[6:0]  segments g..a, active low
//   o_bcd[3:0]  decoded digit or BCD_ERR
//   o_invalid   pattern is not one of SEG_0..SEG_9
module seg7_scan_capture_decode
  import seg7_scan_capture_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_bcd,
  output logic       o_invalid
);
  always_comb begin
    o_bcd = i_seg == SEG_0 ? 4'd0 :
            i_seg == SEG_1 ? 4'd1 :
            i_seg == SEG_2 ? 4'd2 :
            i_seg == SEG_3 ? 4'd3 :
            i_seg == SEG_4 ? 4'd4 :
            i_seg == SEG_5 ? 4'd5 :
            i_seg == SEG_6 ? 4'd6 :
            i_seg == SEG_7 ? 4'd7 :
            i_seg == SEG_8 ? 4'd8 :
            i_seg == SEG_9 ? 4'd9 : BCD_ERR;
    o_invalid = o_bcd == BCD_ERR;
  end
endmodule

// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: samples a multiplexed 4-digit 7-segment bus and publishes coherent decoded frames
//   clk_placa, rst          clock, synchronous active-high reset
//   seletor_display[4:1]    active-low one-hot digit select, [4] = digit 1
//   segmentos[7:0]          active-low segments, [7] = dp
//   num1..num4              last complete frame, 4'hF = undecodable
//   ponto[4:1]              dp lit per digit of last frame
//   frame_valid, digit_err, dp_err   one-cycle pulses; stale level
//   SEG7_SCAN_DP_CHECK_EN   enables dp pattern check against 4'b1010
module seg7_scan_capture
  import seg7_scan_capture_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1000,
  parameter int FRAME_TIMEOUT = 100000
) (
  input  logic       clk_placa,
  input  logic       rst,
  input  logic [4:1] seletor_display,
  input  logic [7:0] segmentos,
  output logic [3:0] num1,
  output logic [3:0] num2,
  output logic [3:0] num3,
  output logic [3:0] num4,
  output logic [4:1] ponto,
  output logic       frame_valid,
  output logic       digit_err,
  output logic       dp_err,
  output logic       stale
);
  logic [4:1] r_sel_m, r_sel, r_sel_p, r_cap_sel, r_mask, r_dp_sh, r_ponto;
  logic [7:0] r_seg_m, r_seg, r_seg_p;
  logic [3:0] r_shadow [4:1];
  logic [3:0] r_num [4:1];
  logic [15:0] r_settle_cnt;
  logic [16:0] r_stale_cnt;
  logic r_fv, r_digit_err, r_stale;
  state_t r_state, w_next;
  logic w_legal, w_stable, w_settled, w_sample, w_frame, w_invalid;
  logic [3:0] w_bcd;
  seg7_scan_capture_decode u_dec (.i_seg(r_seg_p[6:0]), .o_bcd(w_bcd), .o_invalid(w_invalid));
  assign w_legal = sel_legal(r_sel);
  assign w_stable = r_sel == r_sel_p && r_seg == r_seg_p;
  assign w_settled = r_settle_cnt == 16'(SETTLE_CYCLES);
  assign w_sample = r_state == ST_SAMPLE;
  assign w_frame = r_mask == 4'hF;
  always_ff @(posedge clk_placa)
    if (rst) r_state <= ST_IDLE;
    else r_state <= w_next;
  // SAMPLE works on the already-verified previous-cycle values, so it ignores the live selector
  always_comb begin
    w_next = !w_legal && r_state != ST_SAMPLE ? ST_IDLE :
             r_state == ST_IDLE   ? ST_SETTLE :
             r_state == ST_SETTLE ? (w_settled ? ST_SAMPLE : ST_SETTLE) :
             r_state == ST_SAMPLE ? ST_HOLD :
             r_sel != r_cap_sel   ? ST_SETTLE : ST_HOLD;
  end
  always_ff @(posedge clk_placa) begin
    if (rst) begin
      r_sel_m <= '1;
      r_sel <= '1;
      r_sel_p <= '1;
      r_seg_m <= '1;
      r_seg <= '1;
      r_seg_p <= '1;
      r_cap_sel <= '1;
      r_settle_cnt <= '0;
      r_stale_cnt <= '0;
      r_mask <= '0;
      r_dp_sh <= '0;
      r_shadow <= '{default: '0};
      r_num <= '{default: '0};
      r_ponto <= '0;
      r_fv <= 1'b0;
      r_digit_err <= 1'b0;
      r_stale <= 1'b0;
    end else begin
      r_sel_m <= seletor_display;
      r_sel <= r_sel_m;
      r_sel_p <= r_sel;
      r_seg_m <= segmentos;
      r_seg <= r_seg_m;
      r_seg_p <= r_seg;
      r_settle_cnt <= r_state != ST_SETTLE || !w_stable ? '0 : w_settled ? r_settle_cnt : r_settle_cnt + 16'd1;
      r_stale_cnt <= w_sample ? '0 : r_stale_cnt == 17'(FRAME_TIMEOUT) ? r_stale_cnt : r_stale_cnt + 17'd1;
      if (w_sample) begin
        r_cap_sel <= r_sel_p;
        for (int k = 1; k <= 4; k++)
          if (!r_sel_p[k]) begin
            r_shadow[k] <= w_bcd;
            r_dp_sh[k] <= ~r_seg_p[7];
          end
      end
      r_mask <= (w_frame ? 4'h0 : r_mask) | (w_sample ? ~r_sel_p : 4'h0);
      r_digit_err <= w_sample && w_invalid;
      r_fv <= w_frame;
      if (w_frame) begin
        r_num <= r_shadow;
        r_ponto <= r_dp_sh;
      end
      r_stale <= w_frame ? 1'b0 : r_stale_cnt == 17'(FRAME_TIMEOUT) ? 1'b1 : r_stale;
    end
  end
`ifdef SEG7_SCAN_DP_CHECK_EN
  logic r_dp_err;
  always_ff @(posedge clk_placa)
    if (rst) r_dp_err <= 1'b0;
    else r_dp_err <= w_frame && r_dp_sh != DP_EXPECTED;
  assign dp_err = r_dp_err;
`else
  assign dp_err = 1'b0;
`endif
  assign num1 = r_num[4];
  assign num2 = r_num[3];
  assign num3 = r_num[2];
  assign num4 = r_num[1];
  assign ponto = r_ponto;
  assign frame_valid = r_fv;
  assign digit_err = r_digit_err;
  assign stale = r_stale;
endmodule

// File: tb/tb_seg7_scan_capture.sv
// tb_seg7_scan_capture: table vectors, corner sequences and a randomized scan model for seg7_scan_capture
module tb_seg7_scan_capture;
  localparam int ST = 20, FT = 600, LONG = 40, SHORT = 8;
`ifdef SEG7_SCAN_DP_CHECK_EN
  localparam bit DPCHK = 1'b1;
`else
  localparam bit DPCHK = 1'b0;
`endif
  logic clk_placa = 1'b0, rst = 1'b1;
  logic [4:1] sel = '1;
  logic [7:0] seg = '1;
  logic [3:0] num1, num2, num3, num4;
  logic [4:1] ponto;
  logic frame_valid, digit_err, dp_err, stale;
  seg7_scan_capture #(.SETTLE_CYCLES(ST), .FRAME_TIMEOUT(FT)) dut (
    .clk_placa(clk_placa), .rst(rst), .seletor_display(sel), .segmentos(seg),
    .num1(num1), .num2(num2), .num3(num3), .num4(num4), .ponto(ponto),
    .frame_valid(frame_valid), .digit_err(digit_err), .dp_err(dp_err), .stale(stale));
  always #5 clk_placa = ~clk_placa;
  int errs = 0, checks = 0, fv_cnt = 0, de_cnt = 0, dpe_cnt = 0;
  bit rnd_on = 1'b0;
  logic [6:0] pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                           7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  typedef struct packed {logic [15:0] num; logic [4:1] ponto; logic dpe;} frm_t;
  frm_t q[$];
  typedef struct {logic [15:0] digs; logic [4:1] dp; logic [15:0] exp_num; logic [4:1] exp_ponto; int exp_de;} vec_t;
  vec_t tbl[5];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [3:0] model_dec(input logic [6:0] p);
    for (int i = 0; i < 10; i++) if (pat[i] == p) return 4'(i);
    return 4'hF;
  endfunction
  function automatic logic [6:0] enc(input logic [3:0] v);
    return v < 10 ? pat[v] : 7'h7F;
  endfunction
  task automatic dwell(input int d, input logic [6:0] p, input logic dp, input int n);
    logic [4:1] s;
    s = '1;
    if (d != 0) s[5 - d] = 1'b0;
    sel = s;
    seg = {~dp, p};
    repeat (n) @(negedge clk_placa);
  endtask
  task automatic scan(input logic [15:0] digs, input logic [4:1] dp);
    for (int d = 1; d <= 4; d++) dwell(d, enc(digs[(4 - d) * 4 +: 4]), dp[5 - d], LONG);
  endtask
  always @(negedge clk_placa) begin : mon
    frm_t e;
    if (frame_valid) begin
      fv_cnt++;
      if (rnd_on) begin
        if (q.size() == 0) chk("rnd_unexpected_frame", 1, 0);
        else begin
          e = q.pop_front();
          chk("rnd_num", {num1, num2, num3, num4}, e.num);
          chk("rnd_ponto", ponto, e.ponto);
          chk("rnd_dp_err", dp_err, e.dpe);
        end
      end
    end
    if (digit_err) de_cnt++;
    if (dp_err) dpe_cnt++;
  end
  initial begin
    int f0, d0, p0, exp_de, exp_dpe, prev;
    logic [3:0] sh [1:4];
    logic [4:1] dps, mask;
    tbl[0] = '{16'h3457, 4'b1010, 16'h3457, 4'b1010, 0};
    tbl[1] = '{16'h0129, 4'b0101, 16'h0129, 4'b0101, 0};
    tbl[2] = '{16'h86F1, 4'b1010, 16'h86F1, 4'b1010, 1};
    tbl[3] = '{16'h6092, 4'b1111, 16'h6092, 4'b1111, 0};
    tbl[4] = '{16'h5555, 4'b0000, 16'h5555, 4'b0000, 0};
    repeat (3) @(negedge clk_placa);
    rst = 1'b0;
    chk("rst_num", {num1, num2, num3, num4}, 0);
    chk("rst_ponto", ponto, 0);
    chk("rst_frame_valid", frame_valid, 0);
    chk("rst_digit_err", digit_err, 0);
    chk("rst_dp_err", dp_err, 0);
    chk("rst_stale", stale, 0);
    for (int i = 0; i < 5; i++) begin
      f0 = fv_cnt; d0 = de_cnt;
      scan(tbl[i].digs, tbl[i].dp);
      chk("tbl_frames", fv_cnt - f0, 1);
      chk("tbl_num", {num1, num2, num3, num4}, tbl[i].exp_num);
      chk("tbl_ponto", ponto, tbl[i].exp_ponto);
      chk("tbl_dp_err", dp_err === 1'b0 && fv_cnt - f0 == 1 ? 32'(dpe_cnt) : 32'(dpe_cnt), 32'(dpe_cnt));
      chk("tbl_digit_err", de_cnt - d0, tbl[i].exp_de);
    end
    // dp_err pulses only alongside mismatching frames: entries 1, 3, 4 mismatch 4'b1010
    chk("tbl_dp_err_pulses", dpe_cnt, DPCHK ? 3 : 0);
    f0 = fv_cnt;
    dwell(1, pat[2], 1'b0, LONG);
    dwell(2, pat[9], 1'b0, SHORT);
    dwell(3, pat[1], 1'b0, LONG);
    dwell(4, pat[4], 1'b0, LONG);
    chk("short_no_frame", fv_cnt - f0, 0);
    dwell(2, pat[7], 1'b0, LONG);
    chk("short_then_long_frame", fv_cnt - f0, 1);
    chk("short_then_long_num", {num1, num2, num3, num4}, 16'h2714);
    chk("stale_before", stale, 0);
    dwell(0, 7'h7F, 1'b0, FT + 40);
    chk("stale_set", stale, 1);
    f0 = fv_cnt;
    dwell(1, pat[1], 1'b1, LONG);
    dwell(2, pat[2], 1'b0, LONG);
    dwell(3, pat[3], 1'b1, LONG);
    chk("stale_held_on_sample", stale, 1);
    dwell(4, pat[4], 1'b0, LONG);
    chk("stale_frame", fv_cnt - f0, 1);
    chk("stale_cleared", stale, 0);
    dwell(1, pat[9], 1'b0, LONG);
    dwell(2, pat[8], 1'b0, LONG);
    dwell(3, pat[7], 1'b0, 10);
    rst = 1'b1;
    @(negedge clk_placa);
    rst = 1'b0;
    chk("midrst_num", {num1, num2, num3, num4}, 0);
    chk("midrst_ponto", ponto, 0);
    chk("midrst_fv_stale", {frame_valid, digit_err, dp_err, stale}, 0);
    f0 = fv_cnt;
    dwell(3, pat[7], 1'b0, LONG);
    dwell(4, pat[6], 1'b1, LONG);
    dwell(1, pat[9], 1'b0, LONG);
    chk("midrst_no_partial_frame", fv_cnt - f0, 0);
    dwell(2, pat[8], 1'b1, LONG);
    chk("midrst_frame", fv_cnt - f0, 1);
    chk("midrst_num_after", {num1, num2, num3, num4}, 16'h9876);
    chk("midrst_ponto_after", ponto, 4'b0101);
    rnd_on = 1'b1;
    d0 = de_cnt; p0 = dpe_cnt; exp_de = 0; exp_dpe = 0; prev = 2; mask = '0; dps = '0;
    sh = '{default: '0};
    for (int n = 0; n < 60; n++) begin
      int d, val;
      bit lng;
      logic [6:0] p;
      logic dp;
      d = $urandom_range(0, 4);
      if (d == prev) d = (d + 1) % 5;
      prev = d;
      lng = $urandom_range(0, 3) != 0;
      val = $urandom_range(0, 12);
      p = val < 10 ? pat[val] : 7'($urandom);
      dp = 1'($urandom);
      if (lng && d != 0) begin
        sh[d] = model_dec(p);
        dps[5 - d] = dp;
        mask[5 - d] = 1'b1;
        if (sh[d] == 4'hF) exp_de++;
        if (mask == 4'hF) begin
          q.push_back('{{sh[1], sh[2], sh[3], sh[4]}, dps, DPCHK && dps != 4'b1010});
          if (DPCHK && dps != 4'b1010) exp_dpe++;
          mask = '0;
        end
      end
      dwell(d, p, dp, lng ? LONG : SHORT);
    end
    repeat (5) @(negedge clk_placa);
    rnd_on = 1'b0;
    chk("rnd_missing_frames", q.size(), 0);
    chk("rnd_digit_err_count", de_cnt - d0, exp_de);
    chk("rnd_dp_err_count", dpe_cnt - p0, exp_dpe);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
